// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state encoding, defaults and channel-index width for the ADC scan sequencer.
package adc_seq_pkg;
    localparam int NUM_CH_MAX_DEF = 8;
    localparam int DATA_W_DEF     = 24;
    localparam int TIMEOUT_DEF    = 1024;
    localparam int CH_W           = 3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPTURE, S_FINISH} state_e;

    function automatic logic [3:0] eff_count(input logic [3:0] n, input int max_ch);
        return (int'(n) > max_ch) ? 4'(max_ch) : n;
    endfunction
endpackage

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks channels 0..N-1 through an ADC request/ack handshake with a per-channel
// watchdog, writing sign-extended samples into the raw-sample bank.
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH_MAX = NUM_CH_MAX_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              enable,
    input  logic              start,
    input  logic [3:0]        num_ch,
    output logic              adc_req,
    output logic [CH_W-1:0]   adc_ch,
    input  logic              adc_ack,
    input  logic [DATA_W-1:0] adc_data,
    output logic              smp_valid,
    output logic [CH_W-1:0]   smp_ch,
    output logic [31:0]       smp_data,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              overrun
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [3:0]        lim_q, lim_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
    logic [3:0]        eff;
    logic              last_ch, wd_exp;

    assign eff     = eff_count(num_ch, NUM_CH_MAX);
    assign last_ch = ({1'b0, ch_q} + 4'd1) >= lim_q;
    assign wd_exp  = wd_q == WD_W'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        lim_d   = lim_q;
        wd_d    = wd_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        ovr_d   = start && (state_q != S_IDLE);
        // Abort outranks everything, including an ack landing in the same cycle.
        if (state_q != S_IDLE && !enable) begin
            state_d = S_IDLE;
            ch_d    = '0;
            wd_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && enable && eff != 4'd0) begin
                        state_d = S_REQ;
                        ch_d    = '0;
                        wd_d    = '0;
                        lim_d   = eff;
                    end
                end
                S_REQ: begin
                    if (adc_ack) begin
                        data_d  = adc_data;
                        valid_d = 1'b1;
                        state_d = S_CAPTURE;
                    end else if (wd_exp) begin
                        err_d   = 1'b1;
                        state_d = S_CAPTURE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (last_ch) begin
                        state_d = S_FINISH;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        wd_d    = '0;
                        state_d = S_REQ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    ch_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            lim_q   <= '0;
            wd_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            lim_q   <= lim_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc_req     = state_q == S_REQ;
    assign adc_ch      = ch_q;
    assign smp_valid   = valid_q;
    assign smp_ch      = ch_q;
    assign smp_data    = 32'($signed(data_q));
    assign busy        = (state_q == S_REQ) || (state_q == S_CAPTURE);
    assign done        = state_q == S_FINISH;
    assign err_timeout = err_q;
    assign overrun     = ovr_q;
endmodule
